// File: rtl/deserializador_cadena_if.sv
// deserializador_cadena_if: serial input, parallel output and status signals of the receiver
interface deserializador_cadena_if #(parameter int ANCHO = 8);
    logic             inicio;
    logic             dato_serie;
    logic             valido_serie;
    logic             listo_serie;
    logic [ANCHO-1:0] palabra;
    logic             todos_uno;
    logic             palabra_valida;
    logic             palabra_lista;
    logic             ocupado;
    modport master (
        output inicio, dato_serie, valido_serie, palabra_lista,
        input  listo_serie, palabra, todos_uno, palabra_valida, ocupado
    );
    modport slave (
        input  inicio, dato_serie, valido_serie, palabra_lista,
        output listo_serie, palabra, todos_uno, palabra_valida, ocupado
    );
endinterface

// File: rtl/deserializador_cadena.sv
// deserializador_cadena: rebuilds an ANCHO-bit word from an LSB-first serial stream
// and flags whether every received bit was 1.
module deserializador_cadena #(
    parameter int ANCHO = 8
) (
    input logic                    clk,
    input logic                    rst,
    deserializador_cadena_if.slave bus
);
    localparam int CW = $clog2(ANCHO);
    typedef enum logic [1:0] {REPOSO, RECIBIR, ENTREGAR} estado_t;
    estado_t          estado, estado_sig;
    logic [CW-1:0]    cnt;
    logic             acc, toma, ultimo, todos_uno_r;
    logic [ANCHO-1:0] sr, sr_sig, palabra_r;
    always_ff @(posedge clk) begin
        if (rst) estado <= REPOSO;
        else     estado <= estado_sig;
    end
    always_comb begin
        estado_sig         = estado;
        toma               = estado == RECIBIR && bus.valido_serie;
        ultimo             = cnt == CW'(ANCHO - 1);
        sr_sig             = sr;
        sr_sig[cnt]        = bus.dato_serie;
        bus.listo_serie    = estado == RECIBIR;
        bus.palabra_valida = estado == ENTREGAR;
        bus.ocupado        = estado != REPOSO;
        bus.palabra        = palabra_r;
        bus.todos_uno      = todos_uno_r;
        case (estado)
            REPOSO:   estado_sig = bus.inicio ? RECIBIR : REPOSO;
            RECIBIR:  estado_sig = toma && ultimo ? ENTREGAR : RECIBIR;
            ENTREGAR: estado_sig = bus.palabra_lista ? REPOSO : ENTREGAR;
            default:  estado_sig = REPOSO;
        endcase
    end
    // cnt saturates at the last position; the next inicio clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            acc         <= 1'b1;
            sr          <= '0;
            palabra_r   <= '0;
            todos_uno_r <= 1'b0;
        end else if (estado == REPOSO && bus.inicio) begin
            cnt <= '0;
            acc <= 1'b1;
        end else if (toma) begin
            sr  <= sr_sig;
            acc <= acc & bus.dato_serie;
            cnt <= ultimo ? cnt : cnt + CW'(1);
            if (ultimo) begin
                palabra_r   <= sr_sig;
                todos_uno_r <= acc & bus.dato_serie;
            end
        end
    end
endmodule

// File: tb/tb_deserializador_cadena.sv
// tb_deserializador_cadena: directed words on an 8-bit and a 2-bit instance; a
// scoreboard queue per instance is checked by a monitor whenever a word is offered.
module tb_deserializador_cadena;
    logic clk, rst;
    int   checks = 0, errors = 0;
    int   vcnt8 = 0, tomados8 = 0, vcnt2 = 0;
    logic [8:0] q8[$];
    logic [2:0] q2[$];

    deserializador_cadena_if #(.ANCHO(8)) i8();
    deserializador_cadena_if #(.ANCHO(2)) i2();
    deserializador_cadena #(.ANCHO(8)) u8 (.clk(clk), .rst(rst), .bus(i8));
    deserializador_cadena #(.ANCHO(2)) u2 (.clk(clk), .rst(rst), .bus(i2));

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) if (!rst) begin
        if (i8.listo_serie && i8.valido_serie) tomados8++;
        if (i8.palabra_valida) begin
            vcnt8++;
            if (q8.size() == 0) chk("mon8_unexpected_word", 1, 0);
            else begin
                chk("mon8_palabra", i8.palabra, q8[0][7:0]);
                chk("mon8_todos_uno", i8.todos_uno, q8[0][8]);
                chk("mon8_listo_serie", i8.listo_serie, 0);
                if (i8.palabra_lista) void'(q8.pop_front());
            end
        end
        if (i2.palabra_valida) begin
            vcnt2++;
            if (q2.size() == 0) chk("mon2_unexpected_word", 1, 0);
            else begin
                chk("mon2_palabra", i2.palabra, q2[0][1:0]);
                chk("mon2_todos_uno", i2.todos_uno, q2[0][2]);
                if (i2.palabra_lista) void'(q2.pop_front());
            end
        end
    end

    task automatic palabra8(input logic [7:0] v, input bit gap, input int bp);
        q8.push_back({&v, v});
        vcnt8 = 0;
        tomados8 = 0;
        i8.inicio = 1;
        step;
        i8.inicio = 0;
        chk("listo_tras_inicio", i8.listo_serie, 1);
        for (int i = 0; i < 8; i++) begin
            if (gap && i > 0) begin
                i8.valido_serie = 0;
                step;
            end
            i8.valido_serie = 1;
            i8.dato_serie = v[i];
            if (i == 7) begin
                chk("valida_antes_ultimo", i8.palabra_valida, 0);
                if (bp > 0) i8.palabra_lista = 0;
            end
            step;
        end
        i8.valido_serie = 0;
        chk("valida_tras_ultimo", i8.palabra_valida, 1);
        chk("bits_aceptados", tomados8, 8);
        repeat (bp) step;
        i8.palabra_lista = 1;
        step;
        chk("ocupado_fin", i8.ocupado, 0);
        chk("ciclos_valida", vcnt8, bp + 1);
    endtask

    task automatic palabra2(input logic [1:0] v);
        q2.push_back({&v, v});
        vcnt2 = 0;
        i2.inicio = 1;
        step;
        i2.inicio = 0;
        chk("listo2_tras_inicio", i2.listo_serie, 1);
        for (int i = 0; i < 2; i++) begin
            i2.valido_serie = 1;
            i2.dato_serie = v[i];
            step;
        end
        i2.valido_serie = 0;
        chk("valida2_tras_ultimo", i2.palabra_valida, 1);
        step;
        chk("ocupado2_fin", i2.ocupado, 0);
        chk("ciclos_valida2", vcnt2, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        i8.inicio = 1; i8.dato_serie = 0; i8.valido_serie = 0; i8.palabra_lista = 1;
        i2.inicio = 1; i2.dato_serie = 0; i2.valido_serie = 0; i2.palabra_lista = 1;
        repeat (2) step;
        chk("rst_palabra", i8.palabra, 0);
        chk("rst_todos_uno", i8.todos_uno, 0);
        chk("rst_valida", i8.palabra_valida, 0);
        chk("rst_listo", i8.listo_serie, 0);
        chk("rst_ocupado", i8.ocupado, 0);
        chk("rst2_palabra", i2.palabra, 0);
        chk("rst2_listo", i2.listo_serie, 0);
        rst = 0;
        i8.inicio = 0;
        i2.inicio = 0;
        step;
        chk("reposo_listo", i8.listo_serie, 0);

        palabra8(8'hA5, 0, 0);
        palabra8(8'hFF, 1, 0);
        palabra8(8'h3C, 0, 5);

        // inicio mid-word is ignored, then rst discards the partial word
        i8.inicio = 1;
        step;
        i8.inicio = 0;
        for (int i = 0; i < 6; i++) begin
            i8.valido_serie = 1;
            i8.dato_serie = (i < 4);
            i8.inicio = (i == 4);
            step;
        end
        i8.inicio = 0;
        i8.valido_serie = 0;
        chk("ignora_inicio_listo", i8.listo_serie, 1);
        chk("ignora_inicio_ocupado", i8.ocupado, 1);
        rst = 1;
        step;
        rst = 0;
        chk("abort_palabra", i8.palabra, 0);
        chk("abort_todos_uno", i8.todos_uno, 0);
        chk("abort_valida", i8.palabra_valida, 0);
        chk("abort_listo", i8.listo_serie, 0);
        chk("abort_ocupado", i8.ocupado, 0);
        palabra8(8'h81, 0, 0);

        palabra2(2'b11);
        palabra2(2'b01);

        repeat (2) step;
        chk("q8_vacia", q8.size(), 0);
        chk("q2_vacia", q2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
